boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Upstream boot stage for the single-cycle RISC-V core: receives a program image as a byte stream, packs it
//  into 32-bit little-endian words and writes them into instruction memory via its write port.
//  Holds the core in reset (core_rst_o) until the image is complete and its checksum verified; then releases it.
//  Image format: 4-byte LE word count N, N*4 program bytes (LE words), 1 checksum byte = XOR of all preceding bytes.
// PARAMETERS
//  DEPTH_WORDS  1024  instruction memory capacity in words; N > DEPTH_WORDS is an error
//  ADDR_W       32    width of imem_waddr_o (byte address, matches core inst_addr_o)
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous, active-high reset
//  rx_valid_i    in   1       byte stream valid
//  rx_data_i     in   8       byte stream data
//  rx_ready_o    out  1       byte accepted on cycle where rx_valid_i & rx_ready_o
//  reload_i      in   1       1-cycle request to reload a new image (honoured in RUN/ERR only)
//  imem_we_o     out  1       instruction memory write strobe (1 cycle per word)
//  imem_waddr_o  out  ADDR_W  byte address of word written (word index << 2)
//  imem_wdata_o  out  32      word written
//  core_rst_o    out  1       reset to core; high except in RUN
//  done_o        out  1       high while in RUN
//  err_o         out  2       00 none, 01 length > DEPTH_WORDS, 10 checksum mismatch; sticky until rst/reload
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=LEN, byte cnt=0, word idx=0, csum=0, core_rst_o=1, rx_ready_o=1,
//    imem_we_o=0, imem_waddr_o=0, imem_wdata_o=0, done_o=0, err_o=00. Partial words discarded; imem not cleared.
//  - States: LEN -> DATA -> CSUM -> RUN; LEN/CSUM -> ERR. rx_ready_o=1 in LEN/DATA/CSUM, 0 in RUN/ERR.
//  - Every accepted byte in LEN/DATA is XORed into csum register.
//  - LEN: 4 bytes assembled LE into N. On 4th byte: N > DEPTH_WORDS -> ERR, err_o=01; N==0 -> CSUM; else DATA.
//  - DATA: bytes packed LE (first byte -> [7:0]). Cycle after 4th byte of word k accepted: imem_we_o=1,
//    imem_waddr_o=k*4, imem_wdata_o=word, for exactly one cycle; write latency 1 cycle. After word N-1 -> CSUM.
//  - Back-to-back bytes at full rate (one per cycle) must be accepted with no bubbles; no backpressure in DATA.
//  - CSUM: one byte. Equal to csum -> RUN; else ERR, err_o=10. Checksum byte not written to imem.
//  - core_rst_o, done_o registered: change on the cycle after the transition edge (core_rst_o falls
//    the cycle after the good checksum byte is accepted).
//  - RUN: rx bytes ignored (not accepted). reload_i=1 -> LEN, core_rst_o=1, done_o=0, counters/csum cleared.
//  - ERR: core_rst_o stays 1; reload_i=1 -> LEN with err_o cleared to 00.
//  - reload_i in LEN/DATA/CSUM ignored. rst has priority over reload_i and rx activity.
//  - Word index counter width clog2(DEPTH_WORDS)+1; never wraps because N bounded by DEPTH_WORDS.
//  - N == DEPTH_WORDS accepted; last write at address (DEPTH_WORDS-1)*4.
// STRUCTURE
//  - Shared package boot_pkg: state encoding (LEN, DATA, CSUM, RUN, ERR), err codes (ERR_NONE/ERR_LEN/ERR_CSUM),
//    image header length constant (4 bytes).
//  - One sub-module boot_word_pack: 4-byte LE shift/pack with byte counter, clear input, word_valid pulse.
//  - Top holds FSM, N register, word index, XOR checksum, registered imem write port and core_rst_o.
// TESTING
//  - Reset: hold rst 3 cycles mid-DATA -> core_rst_o=1, err_o=00, imem_we_o=0, partial word never written.
//  - Good image N=2, words 0x00000013, 0x00100093, csum=0x02^0x13^0x93^0x10=0x92 -> two writes at addr 0x0,
//    0x4 with those values, core_rst_o falls 1 cycle after csum byte, done_o=1.
//  - N=0 (bytes 00 00 00 00, csum 00) -> no imem writes, RUN reached; csum 0x01 instead -> ERR, err_o=10.
//  - DEPTH_WORDS=4, N=5 -> ERR after 4th length byte, err_o=01, rx_ready_o=0, no imem writes.
//  - Full-rate stream with random rx_valid_i gaps -> identical imem contents; bytes sent in RUN not accepted.
//  - reload_i in RUN -> core_rst_o=1 next cycle, second image overwrites imem; reload_i in DATA ignored.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states, error codes and
// image framing constants.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } boot_state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_LEN  = 2'b01,
      ERR_CSUM = 2'b10
   } boot_err_e;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;

   // Word index must be able to hold DEPTH_WORDS itself, hence the extra bit.
   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream receive port and instruction-memory write port of the boot loader.
interface boot_loader_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              rx_valid_i;
   logic [7:0]        rx_data_i;
   logic              rx_ready_o;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_waddr_o;
   logic [31:0]       imem_wdata_o;

   modport slave (
      input  rx_valid_i, rx_data_i,
      output rx_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o
   );

   modport master (
      output rx_valid_i, rx_data_i,
      input  rx_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o
   );
endinterface

// File: rtl/boot_word_pack.sv
// Packs a byte stream into 32-bit little-endian words; word_valid is
// combinational on the cycle the fourth byte of a word is presented.
module boot_word_pack
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_cnt;
   logic [23:0] shift;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_cnt <= '0;
         shift    <= '0;
      end else if (byte_valid) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift    <= {byte_data, shift[23:8]};
      end
   end

   // Earlier bytes sit in the low lanes; the current byte completes [31:24].
   assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));
   assign word       = {byte_data, shift};

endmodule

// File: rtl/boot_loader.sv
// Boot stage: receives length-prefixed, XOR-checksummed image, writes it to
// instruction memory and releases the core from reset once it is verified.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 32
)(
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.slave  bus,
   input  logic          reload_i,
   output logic          core_rst_o,
   output logic          done_o,
   output logic [1:0]    err_o
);

   localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);

   boot_state_e        state, state_nxt;
   boot_err_e          err, err_nxt;
   logic [IDX_W-1:0]   n_words;
   logic [IDX_W-1:0]   word_idx;
   logic [7:0]         csum;
   logic               we_q;
   logic [ADDR_W-1:0]  waddr_q;
   logic [31:0]        wdata_q;
   logic               core_rst_q;
   logic               done_q;

   logic               accept;
   logic               pack_en;
   logic               pack_valid;
   logic [31:0]        pack_word;
   logic               reload_go;
   logic               len_too_big;
   logic               last_word;

   assign bus.rx_ready_o = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
   assign accept         = bus.rx_valid_i && bus.rx_ready_o;
   assign pack_en        = accept && ((state == ST_LEN) || (state == ST_DATA));
   assign reload_go      = reload_i && ((state == ST_RUN) || (state == ST_ERR));
   assign len_too_big    = pack_word > 32'(DEPTH_WORDS);
   assign last_word      = (word_idx + IDX_W'(1)) == n_words;

   // Length header and data words share one packer; it realigns every 4 bytes.
   boot_word_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .clr        (reload_go),
      .byte_valid (pack_en),
      .byte_data  (bus.rx_data_i),
      .word_valid (pack_valid),
      .word       (pack_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_LEN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err;
      case (state)
         ST_LEN: begin
            if (pack_valid) begin
               if (len_too_big) begin
                  state_nxt = ST_ERR;
                  err_nxt   = ERR_LEN;
               end else if (pack_word == '0) begin
                  state_nxt = ST_CSUM;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (pack_valid && last_word) begin
               state_nxt = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (bus.rx_data_i == csum) begin
                  state_nxt = ST_RUN;
               end else begin
                  state_nxt = ST_ERR;
                  err_nxt   = ERR_CSUM;
               end
            end
         end
         ST_RUN: begin
            if (reload_i) begin
               state_nxt = ST_LEN;
            end
         end
         ST_ERR: begin
            if (reload_i) begin
               state_nxt = ST_LEN;
               err_nxt   = ERR_NONE;
            end
         end
         default: begin
            state_nxt = ST_LEN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_words    <= '0;
         word_idx   <= '0;
         csum       <= '0;
         err        <= ERR_NONE;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         we_q       <= 1'b0;
         err        <= err_nxt;
         core_rst_q <= (state_nxt != ST_RUN);
         done_q     <= (state_nxt == ST_RUN);
         if (reload_go) begin
            n_words  <= '0;
            word_idx <= '0;
            csum     <= '0;
         end else begin
            if (pack_en) begin
               csum <= csum ^ bus.rx_data_i;
            end
            if ((state == ST_LEN) && pack_valid) begin
               n_words <= pack_word[IDX_W-1:0];
            end
            if ((state == ST_DATA) && pack_valid) begin
               we_q     <= 1'b1;
               waddr_q  <= ADDR_W'(word_idx) << 2;
               wdata_q  <= pack_word;
               word_idx <= word_idx + IDX_W'(1);
            end
         end
      end
   end

   assign bus.imem_we_o    = we_q;
   assign bus.imem_waddr_o = waddr_q;
   assign bus.imem_wdata_o = wdata_q;
   assign core_rst_o       = core_rst_q;
   assign done_o           = done_q;
   assign err_o            = err;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected imem writes are queued by the
// stimulus and matched by a negedge monitor; status outputs checked inline.
module tb_boot_loader;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       reload_i;
   logic       core_rst_o;
   logic       done_o;
   logic [1:0] err_o;

   boot_loader_if #(.ADDR_W(32)) bus ();

   boot_loader #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .reload_i   (reload_i),
      .core_rst_o (core_rst_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          checks   = 0;
   int          errors   = 0;
   int          accepted = 0;
   int          acc0;
   logic [31:0] wbuf [0:3];
   logic [7:0]  good_img [0:12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rx_valid_i && bus.rx_ready_o) accepted++;
      if (bus.imem_we_o !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                     bus.imem_waddr_o, bus.imem_wdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", bus.imem_waddr_o, mon_e.addr);
            check("wr_data", bus.imem_wdata_o, mon_e.data);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      @(posedge clk);
      #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic pulse_reload();
      reload_i = 1'b1;
      cycle();
      reload_i = 1'b0;
   endtask

   // Sends header, nw words from wbuf and XOR checksum (optionally corrupted).
   task automatic send_img(input logic [31:0] n, input int unsigned nw, input bit gaps,
                           input bit bad, input int reload_at);
      logic [7:0] q[$];
      logic [7:0] cs;
      logic [31:0] w;
      cs = 8'h00;
      for (int unsigned i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
      for (int unsigned k = 0; k < nw; k++) begin
         w = wbuf[k];
         exp_q.push_back('{addr: 32'(k * 4), data: w});
         for (int unsigned i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
      end
      foreach (q[i]) cs = cs ^ q[i];
      q.push_back(bad ? (cs ^ 8'h01) : cs);
      foreach (q[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) cycle();
         reload_i = (i == reload_at);
         send_byte(q[i]);
         reload_i = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      good_img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
      rst            = 1'b1;
      reload_i       = 1'b0;
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_core_rst", 32'(core_rst_o), 32'd1);
      check("rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_we", 32'(bus.imem_we_o), 32'd0);
      check("rst_waddr", bus.imem_waddr_o, 32'h0);
      check("rst_wdata", bus.imem_wdata_o, 32'h0);

      // Hand-built two-word image, checksum 0x92
      exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
      exp_q.push_back('{addr: 32'h4, data: 32'h0010_0093});
      for (int unsigned i = 0; i < 12; i++) send_byte(good_img[i]);
      check("core_rst_before_csum", 32'(core_rst_o), 32'd1);
      send_byte(good_img[12]);
      check("good_core_rst", 32'(core_rst_o), 32'd0);
      check("good_done", 32'(done_o), 32'd1);
      check("good_rx_ready", 32'(bus.rx_ready_o), 32'd0);
      check("good_err", 32'(err_o), 32'd0);

      acc0 = accepted;
      repeat (3) send_byte(8'hAA);
      check("run_bytes_ignored", 32'(accepted - acc0), 32'd0);
      check("run_done_held", 32'(done_o), 32'd1);

      pulse_reload();
      check("reload_core_rst", 32'(core_rst_o), 32'd1);
      check("reload_done", 32'(done_o), 32'd0);
      check("reload_rx_ready", 32'(bus.rx_ready_o), 32'd1);

      // N == DEPTH with random gaps; reload pulsed mid-DATA must be ignored
      wbuf = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C};
      send_img(32'd4, 4, 1'b1, 1'b0, 9);
      check("full_done", 32'(done_o), 32'd1);
      check("full_core_rst", 32'(core_rst_o), 32'd0);
      check("full_err", 32'(err_o), 32'd0);

      pulse_reload();
      send_img(32'd0, 0, 1'b0, 1'b0, -1);
      check("n0_done", 32'(done_o), 32'd1);
      check("n0_err", 32'(err_o), 32'd0);

      pulse_reload();
      send_img(32'd0, 0, 1'b0, 1'b1, -1);
      check("badcs_err", 32'(err_o), 32'd2);
      check("badcs_core_rst", 32'(core_rst_o), 32'd1);
      check("badcs_done", 32'(done_o), 32'd0);
      check("badcs_rx_ready", 32'(bus.rx_ready_o), 32'd0);

      pulse_reload();
      check("err_clear", 32'(err_o), 32'd0);
      check("err_reload_rx_ready", 32'(bus.rx_ready_o), 32'd1);
      check("err_reload_core_rst", 32'(core_rst_o), 32'd1);

      // N = DEPTH+1 rejected after the fourth length byte
      send_byte(8'h05);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("len_err", 32'(err_o), 32'd1);
      check("len_rx_ready", 32'(bus.rx_ready_o), 32'd0);
      acc0 = accepted;
      repeat (4) send_byte(8'h13);
      check("len_err_ignored", 32'(accepted - acc0), 32'd0);
      check("len_err_held", 32'(err_o), 32'd1);

      // Reset mid-DATA: first word lands, trailing partial word is discarded
      pulse_reload();
      exp_q.push_back('{addr: 32'h0, data: 32'h1122_3344});
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      send_byte(8'h55); send_byte(8'h66);
      rst = 1'b1;
      for (int unsigned c = 0; c < 3; c++) begin
         cycle();
         check("midrst_core_rst", 32'(core_rst_o), 32'd1);
         check("midrst_err", 32'(err_o), 32'd0);
         check("midrst_we", 32'(bus.imem_we_o), 32'd0);
      end
      rst = 1'b0;
      wbuf[0] = 32'hAABB_CCDD;
      send_img(32'd1, 1, 1'b0, 1'b0, -1);
      check("post_rst_done", 32'(done_o), 32'd1);

      repeat (2) cycle();
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
